// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types and constants for the FIR stream controller.
//   fir_state_e : controller FSM states
//   DATA_W_DEF  : default sample/result width
package fir_ctrl_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } fir_state_e;

endpackage

// File: rtl/token_delay_line.sv
// token_delay_line: fixed-depth shift register carrying {valid,last} tokens
// alongside the external FIR datapath so the output side knows which fir_y
// values are real samples.
//   clk, rstN : clock, async active-low reset (clears all tokens)
//   tok_in    : {valid,last} issued on the same edge fir_x is updated
//   tok_out   : token after DEPTH register stages
module token_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] tok_in,
  output logic [1:0] tok_out
);

  logic [DEPTH-1:0][1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tok_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign tok_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: record sequencer for an external FIR datapath.
// Primes the filter with FLUSH_LEN zeros, streams accepted samples into fir_x,
// then flushes FLUSH_LEN zeros so the tail of the response comes out. A token
// line tracks which fir_y values are outputs and which one is the last.
//   start/in_*  : record start pulse and sample input (in_ready = accepting)
//   fir_x/fir_y : FIR datapath drive / response (fir_y lags fir_x by LATENCY)
//   out_*       : filtered output stream, no backpressure
//   busy/done   : status; done pulses with the final output beat
//   underrun    : sticky, source went idle during RUN
//   sample_cnt  : accepted samples this record (saturating)
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LATENCY   = 1,
  parameter int FLUSH_LEN = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] fir_x,
  input  logic [DATA_W-1:0] fir_y,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int              PH_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [PH_W-1:0] PH_END = PH_W'(FLUSH_LEN - 1);

  fir_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [DATA_W-1:0] fir_x_q, fir_x_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              done_q, done_d, underrun_q, underrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        tok_in, tok_out;   // {valid,last}
  logic              accept;

  assign accept = (state_q == ST_RUN) && in_valid;

  // Token enters the line on the fir_x edge; DEPTH = LATENCY+1 plus the
  // out_valid register lines it up with fir_y being captured into out_data.
  token_delay_line #(.DEPTH(LATENCY + 1)) u_tok (
    .clk    (clk),
    .rstN   (rstN),
    .tok_in (tok_in),
    .tok_out(tok_out)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      fir_x_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      fir_x_q     <= fir_x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state. ph counts the FLUSH_LEN cycles of PRIME and FLUSH and idles
  // at zero elsewhere so both phases start from a clean count.
  always_comb begin
    state_d = state_q;
    ph_d    = '0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_PRIME;
      ST_PRIME: begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PH_END) begin
          state_d = ST_RUN;
          ph_d    = '0;
        end
      end
      ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
      ST_FLUSH: begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PH_END) begin
          state_d = ST_DRAIN;
          ph_d    = '0;
        end
      end
      ST_DRAIN: if (tok_out == 2'b11) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath registers.
  always_comb begin
    fir_x_d    = '0;
    tok_in     = 2'b00;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    in_ready   = (state_q == ST_RUN);
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (start) begin
        cnt_d      = '0;
        underrun_d = 1'b0;
      end
      ST_RUN: if (in_valid) begin
        fir_x_d = in_data;
        tok_in  = 2'b10;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
      ST_FLUSH: tok_in = {1'b1, (ph_q == PH_END)};
      ST_DRAIN: done_d = (tok_out == 2'b11);
      default: ;
    endcase
    out_valid_d = tok_out[1];
    out_last_d  = tok_out[0];
    out_data_d  = tok_out[1] ? fir_y : out_data_q;
  end

  assign fir_x      = fir_x_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
module tb_fir_stream_ctrl;
  localparam int DW = 16, LAT = 1, FL = 3, CW = 16;
  typedef logic [DW-1:0] dq_t[$];

  logic clk = 1'b0, rstN = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0, fir_y, fir_x, out_data;
  logic in_ready, out_valid, out_last, busy, done, underrun;
  logic [CW-1:0] sample_cnt;

  int total = 0, pass_cnt = 0, cyc = 0;
  logic [DW-1:0] obs_data[$];
  bit obs_last[$];
  int obs_cyc[$];
  int done_cnt = 0, done_ok = 0, first_acc = -1;

  always #5 clk = ~clk;

  fir_stream_ctrl #(.DATA_W(DW), .LATENCY(LAT), .FLUSH_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .fir_x(fir_x), .fir_y(fir_y),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
    .done(done), .underrun(underrun), .sample_cnt(sample_cnt)
  );

  // identity FIR with one cycle of latency
  always_ff @(posedge clk) fir_y <= fir_x;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor, sampled away from the active edge
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      obs_data.push_back(out_data);
      obs_last.push_back(out_last);
      obs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (out_valid && out_last) done_ok++;
    end
    if (first_acc < 0 && in_valid && in_ready) first_acc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_cnt = 0; done_ok = 0; first_acc = -1;
  endtask

  // Drive one record; gap_at inserts an idle cycle before that sample,
  // start_at raises start alongside that sample. Checks against the rule:
  // outputs = accepted samples followed by FL zeros, last flag on the final one.
  task automatic run_record(input string tag, input dq_t smp, input int gap_at, input int start_at);
    dq_t expq;
    int n, w, m;
    n = smp.size();
    expq = smp;
    for (int i = 0; i < FL; i++) expq.push_back('0);
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk({tag, " prime_len"}, w, FL);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; in_data = smp[i]; in_last = (i == n - 1); start = (i == start_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; in_data = '0;
    w = 0;
    while (done_cnt == 0 && w < 60) begin @(posedge clk); #1; w++; end
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " done_with_last"}, done_ok, 1);
    chk({tag, " beats"}, obs_data.size(), expq.size());
    m = (obs_data.size() < expq.size()) ? obs_data.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), obs_data[i], expq[i]);
      chk($sformatf("%s last[%0d]", tag, i), obs_last[i], (i == expq.size() - 1));
    end
    if (obs_cyc.size() > 0) begin
      chk({tag, " latency"}, obs_cyc[0] - first_acc, LAT + 2);
      if (gap_at < 0)
        chk({tag, " contiguous"}, obs_cyc[obs_cyc.size()-1] - obs_cyc[0], expq.size() - 1);
    end
    chk({tag, " sample_cnt"}, sample_cnt, n);
    chk({tag, " underrun"}, underrun, (gap_at >= 0));
    chk({tag, " busy_after"}, busy, 0);
  endtask

  initial begin
    dq_t q;
    int n, gap;
    #17;
    chk("reset_outputs", {in_ready, fir_x, out_valid, out_data, out_last, busy, done, underrun, sample_cnt}, 0);
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", {in_ready, fir_x, out_valid, busy, done, underrun, sample_cnt}, 0);

    q = '{16'd100, 16'd200, 16'd300, 16'd400};
    run_record("V1", q, -1, -1);
    q = '{16'hFFFB};
    run_record("V2", q, -1, -1);
    q = '{16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
    run_record("V3", q, 2, -1);
    q = '{16'd21, 16'd22, 16'd23};
    run_record("V5", q, -1, 1);
    q = '{16'h7FFF, 16'h8000};
    run_record("V6", q, -1, -1);

    for (int r = 0; r < 4; r++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
      gap = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      run_record($sformatf("R%0d", r), q, gap, -1);
    end

    // V4: reset during FLUSH with tokens in flight
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(50 + i); in_last = (i == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(posedge clk); #1;
    chk("V4 pre_busy", busy, 1);
    chk("V4 pre_out_valid", out_valid, 1);
    #2 rstN = 1'b0;
    #1;
    clear_mon();
    chk("V4 reset_outputs", {in_ready, fir_x, out_valid, out_data, out_last, busy, done, underrun, sample_cnt}, 0);
    #10 rstN = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("V4 no_out_valid", obs_data.size(), 0);
    chk("V4 no_done", done_cnt, 0);
    chk("V4 busy", busy, 0);

    q = '{16'd1, 16'd2};
    run_record("V4R", q, -1, -1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample/result width (signed).
REQ-002 SHALL have parameter LATENCY, default 1, FIR cycles from fir_x update to matching fir_y (1..8).
REQ-003 SHALL have parameter FLUSH_LEN, default 3, zero samples driven for prime and tail flush (= tap count).
REQ-004 SHALL have parameter CNT_W, default 16, sample counter width.
REQ-005 SHALL have ports, in order:
  clk  in  1  sole clock, rising edge.
  rstN  in  1  asynchronous active-low reset.
  start  in  1  one-cycle pulse; begins a record when IDLE.
  in_valid  in  1  source sample valid.
  in_data  in  DATA_W  signed input sample.
  in_last  in  1  marks the final sample of the record.
  in_ready  out  1  controller accepts a sample this cycle.
  fir_x  out  DATA_W  registered sample to FIR datapath x.
  fir_y  in  DATA_W  FIR datapath output y.
  out_valid  out  1  out_data holds a valid filtered sample.
  out_data  out  DATA_W  registered copy of fir_y.
  out_last  out  1  with out_valid, marks the final output of the record.
  busy  out  1  high in any state but IDLE.
  done  out  1  one-cycle pulse at record completion.
  underrun  out  1  sticky: in_valid low during RUN.
  sample_cnt  out  CNT_W  accepted input samples in current record.

Function
REQ-006 SHALL implement FSM IDLE -> PRIME -> RUN -> FLUSH -> DRAIN -> IDLE.
REQ-007 IDLE: fir_x=0, in_ready=0; start moves to PRIME, clears sample_cnt and underrun; start outside IDLE is ignored.
REQ-008 PRIME: drive fir_x=0 for FLUSH_LEN cycles, no tokens issued, then RUN.
REQ-009 RUN: in_ready=1; each cycle with in_valid: fir_x<=in_data, sample_cnt+=1 (saturating at all-ones), issue valid token.
REQ-010 RUN with in_valid=0: fir_x<=0, no token issued, underrun<=1, state stays RUN.
REQ-011 Accepting a sample with in_last=1 SHALL move to FLUSH the following cycle.
REQ-012 FLUSH: in_ready=0; drive fir_x=0 for FLUSH_LEN cycles, each issuing a valid token; the final one carries a last flag; then DRAIN.
REQ-013 Token delay line SHALL carry {valid,last} so out_valid/out_last assert exactly LATENCY+1 cycles after fir_x is updated, with out_data<=fir_y on that edge.
REQ-014 DRAIN: wait until the last-flagged token emerges; that cycle pulses done and returns to IDLE.
REQ-015 A record of N accepted samples SHALL produce exactly N+FLUSH_LEN out_valid beats, one per cycle absent underrun.
REQ-016 in_last on the first accepted sample (N=1) SHALL be legal and yield 1+FLUSH_LEN outputs.
REQ-017 No output backpressure: out_valid beats are never stalled or dropped.

Reset
REQ-018 rstN low SHALL asynchronously force state IDLE, fir_x=0, out_data=0, all token bits 0, out_valid=0, out_last=0, done=0, underrun=0, sample_cnt=0, busy=0, in_ready=0.
REQ-019 Reset mid-record SHALL discard all in-flight tokens; no out_valid or done after release until a new start.

Structure
REQ-020 Package fir_ctrl_pkg SHALL hold the state enum type and the default DATA_W constant.
REQ-021 Token delay line SHALL be sub-module token_delay_line (depth parameterised, 2-bit payload, async active-low reset); FIR datapath instantiated outside this block.

Verification
REQ-022 Bench SHALL pair the block with an identity model (fir_y = fir_x delayed LATENCY=1) and cover:
  V1: start, samples 100,200,300,400 (last on 400), in_valid continuous -> 7 out_valid beats 100,200,300,400,0,0,0; out_last on 7th; done 1 cycle later than 7th? no: done same cycle as 7th beat; sample_cnt=4.
  V2: single sample -5 with in_last -> outputs -5,0,0,0; sample_cnt=1.
  V3: in_valid dropped one cycle mid-record -> underrun=1 sticky, output count still N+3.
  V4: rstN pulsed low during FLUSH -> all outputs 0 immediately, no done, busy=0.
  V5: start during RUN -> ignored, sample_cnt unaffected.
  V6: values 32767 and -32768 -> passed bit-exact through out_data.
